// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - funct3 encodings for the supported access sizes
//   - FSM state type used by load_store_unit
//   - is_fault(): decides at accept time whether a request is rejected
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_LD_DONE,
    ST_WR,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_ERR
  } lsu_state_t;

  // Misaligned halfword/word, unknown funct3, or an unsigned-only
  // size used on a store.
  function automatic logic is_fault(input logic       write,
                                    input logic [2:0] funct3,
                                    input logic [1:0] addr_lo);
    logic f;
    case (funct3)
      F3_B:    f = 1'b0;
      F3_H:    f = addr_lo[0];
      F3_W:    f = (addr_lo != 2'b00);
      F3_BU:   f = write;
      F3_HU:   f = write | addr_lo[0];
      default: f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/byte_lane_align.sv
// byte_lane_align: combinational lane steering for the load/store unit.
// Ports:
//   i_funct3     access size / signedness
//   i_addr_lo    byte offset within the word
//   i_mem_word   word read from memory
//   i_wdata      right-aligned store data
//   o_load_data  extracted and sign/zero-extended load result
//   o_store_data memory word with the addressed lane(s) replaced
module byte_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_mem_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_mem_word[{i_addr_lo, 3'b000} +: 8];
    w_half = i_addr_lo[1] ? i_mem_word[31:16] : i_mem_word[15:0];

    o_load_data = '0;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_W:    o_load_data = i_mem_word;
      F3_BU:   o_load_data = {24'h000000, w_byte};
      F3_HU:   o_load_data = {16'h0000, w_half};
      default: o_load_data = '0;
    endcase

    o_store_data = i_mem_word;
    case (i_funct3)
      F3_B: o_store_data[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
      F3_H: begin
        if (i_addr_lo[1]) o_store_data[31:16] = i_wdata[15:0];
        else              o_store_data[15:0]  = i_wdata[15:0];
      end
      F3_W:    o_store_data = i_wdata;
      default: o_store_data = i_mem_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage initiator for a word-addressed data memory.
// Loads read one word and extract/extend the addressed lane; sub-word
// stores are read-modify-write; full-word stores write directly.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_write/req_funct3/req_addr/req_wdata  pipeline request
//   busy                      stall, high whenever not IDLE
//   resp_valid/resp_rdata/fault  registered one-cycle completion
//   mem_write/mem_address/mem_write_data/mem_read_data  memory port
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int address_width = 12,
  parameter int data_width    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic                     req_write,
  input  logic [2:0]               req_funct3,
  input  logic [address_width-1:0] req_addr,
  input  logic [data_width-1:0]    req_wdata,
  output logic                     busy,
  output logic                     resp_valid,
  output logic [data_width-1:0]    resp_rdata,
  output logic                     fault,
  output logic                     mem_write,
  output logic [address_width-1:0] mem_address,
  output logic [data_width-1:0]    mem_write_data,
  input  logic [data_width-1:0]    mem_read_data
);

  lsu_state_t               r_state;
  logic [address_width-1:0] r_addr;
  logic [data_width-1:0]    r_wdata;
  logic [2:0]               r_funct3;
  logic                     r_write;
  logic                     r_resp_valid;
  logic [data_width-1:0]    r_resp_rdata;
  logic                     r_fault;

  logic [data_width-1:0]    w_load_data;
  logic [data_width-1:0]    w_store_data;
  logic                     w_wr_state;

  byte_lane_align u_align (
    .i_funct3     (r_funct3),
    .i_addr_lo    (r_addr[1:0]),
    .i_mem_word   (mem_read_data),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_store_data (w_store_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_funct3     <= '0;
      r_write      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_fault      <= 1'b0;
    end else begin
      // Response registers are single-cycle pulses; zero otherwise.
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_fault      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_funct3 <= req_funct3;
            r_write  <= req_write;
            if (is_fault(req_write, req_funct3, req_addr[1:0]))
              r_state <= ST_ERR;
            else if (!req_write)
              r_state <= ST_RD;
            else if (req_funct3 == F3_W)
              r_state <= ST_WR;
            else
              r_state <= ST_RMW_RD;
          end
        end
        ST_RD:     r_state <= ST_LD_DONE;
        ST_LD_DONE: begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= w_load_data;
          r_state      <= ST_IDLE;
        end
        ST_WR: begin
          r_resp_valid <= 1'b1;
          r_state      <= ST_IDLE;
        end
        ST_RMW_RD: r_state <= ST_RMW_WR;
        ST_RMW_WR: begin
          r_resp_valid <= 1'b1;
          r_state      <= ST_IDLE;
        end
        ST_ERR: begin
          r_resp_valid <= 1'b1;
          r_fault      <= 1'b1;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_wr_state     = (r_state == ST_WR) || (r_state == ST_RMW_WR);
    // Reset in a write cycle must suppress the write in that same cycle.
    mem_write      = w_wr_state & r_write & ~rst;
    mem_address    = {r_addr[address_width-1:2], 2'b00};
    mem_write_data = w_wr_state ? w_store_data : '0;
    busy           = (r_state != ST_IDLE);
    resp_valid     = r_resp_valid;
    resp_rdata     = r_resp_rdata;
    fault          = r_fault;
  end

endmodule
